// File: rtl/input_fifo.sv
// input_fifo: credit-based first-word-fall-through input buffer for one router channel.
// Drives the LBDR head-flit fields and returns one credit per flit consumed.
module input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic                  credit_out,
    output logic                  overflow_err
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic rd, wr;
    assign empty    = count == '0;
    assign full     = count == (AW+1)'(DEPTH);
    assign rd       = read_en & ~empty;
    // Writing into a full buffer is legal when the head slot is freed this cycle.
    assign wr       = valid_in & (~full | rd);
    assign data_out = mem[rd_ptr];
    assign flit_id  = data_out[DATA_WIDTH-1 -: 3];
    assign dst_addr = data_out[DATA_WIDTH-4 -: 4];
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= data_in;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count      <= (wr & ~rd) ? count + 1'b1 : (rd & ~wr) ? count - 1'b1 : count;
            credit_out <= rd;
            if (valid_in & full & ~rd) overflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_input_fifo.sv
// tb_input_fifo: directed stimulus with a scoreboard queue and an independent output monitor.
module tb_input_fifo;
    logic        clk, rst, valid_in, read_en;
    logic [31:0] data_in, data_out;
    logic [2:0]  flit_id;
    logic [3:0]  dst_addr;
    logic        empty, full, credit_out, overflow_err;
    int tests = 0, fails = 0;
    logic [31:0] sb [$];
    logic prev_rd = 1'b0;

    input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .read_en(read_en),
        .data_out(data_out), .flit_id(flit_id), .dst_addr(dst_addr), .empty(empty),
        .full(full), .credit_out(credit_out), .overflow_err(overflow_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic push);
        valid_in = v;
        data_in  = d;
        read_en  = r;
        if (push) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a read happens at the next edge whenever read_en is high and data is held.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) prev_rd = 1'b0;
            else begin
                chk("credit", {31'b0, credit_out}, {31'b0, prev_rd});
                prev_rd = read_en & ~empty;
                if (read_en && !empty) begin
                    if (sb.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("data_out", data_out, e);
                        chk("flit_id", {29'b0, flit_id}, {29'b0, e[31:29]});
                        chk("dst_addr", {28'b0, dst_addr}, {28'b0, e[28:25]});
                    end
                end
            end
        end
    end

    task automatic async_reset();
        valid_in = 0;
        read_en  = 0;
        #1 rst = 1;
        #1;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_credit", {31'b0, credit_out}, 32'd0);
        chk("rst_ovf", {31'b0, overflow_err}, 32'd0);
        sb.delete();
        #1 rst = 0;
    endtask

    initial begin
        rst = 1; valid_in = 0; read_en = 0; data_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("init_empty", {31'b0, empty}, 32'd1);
        chk("init_full", {31'b0, full}, 32'd0);
        chk("init_credit", {31'b0, credit_out}, 32'd0);
        chk("init_ovf", {31'b0, overflow_err}, 32'd0);
        repeat (3) step(0, 0, 1, 0);
        chk("idle_empty", {31'b0, empty}, 32'd1);
        chk("idle_credit", {31'b0, credit_out}, 32'd0);
        // Packet: HEADER dst 1010, PAYLOAD, TAIL
        step(1, 32'h3400_0012, 0, 1);
        chk("hdr_id", {29'b0, flit_id}, 32'd1);
        chk("hdr_dst", {28'b0, dst_addr}, 32'hA);
        chk("hdr_empty", {31'b0, empty}, 32'd0);
        step(1, 32'h0000_BEEF, 0, 1);
        step(1, 32'h8000_00AA, 0, 1);
        chk("pkt_tail_wait_credit", {31'b0, credit_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("pkt_credit", {31'b0, credit_out}, 32'd1);
        end
        chk("pkt_empty", {31'b0, empty}, 32'd1);
        step(0, 0, 0, 0);
        chk("pkt_credit_off", {31'b0, credit_out}, 32'd0);
        // Fill and overflow
        for (int i = 0; i < 4; i++) step(1, 32'h10 + i, 0, 1);
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_ovf0", {31'b0, overflow_err}, 32'd0);
        step(1, 32'h14, 0, 0);
        chk("ovf_set", {31'b0, overflow_err}, 32'd1);
        chk("ovf_full", {31'b0, full}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("drain_empty", {31'b0, empty}, 32'd1);
        chk("ovf_sticky", {31'b0, overflow_err}, 32'd1);
        async_reset();
        // Full with simultaneous read/write
        for (int i = 0; i < 4; i++) step(1, 32'h20 + i, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, i, 1, 1);
            chk("rw_full", {31'b0, full}, 32'd1);
            chk("rw_ovf", {31'b0, overflow_err}, 32'd0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("rw_empty", {31'b0, empty}, 32'd1);
        // Write while empty with read_en high
        step(1, 32'h55, 1, 1);
        chk("wre_empty", {31'b0, empty}, 32'd0);
        chk("wre_credit", {31'b0, credit_out}, 32'd0);
        chk("wre_data", data_out, 32'h55);
        step(0, 0, 1, 0);
        chk("wre_rd_credit", {31'b0, credit_out}, 32'd1);
        chk("wre_rd_empty", {31'b0, empty}, 32'd1);
        // Async reset with 3 flits held and a credit pulse in flight
        for (int i = 0; i < 4; i++) step(1, 32'h61 + i, 0, 1);
        step(0, 0, 1, 0);
        chk("pre_rst_credit", {31'b0, credit_out}, 32'd1);
        async_reset();
        step(1, 32'h3000_0071, 0, 1);
        step(1, 32'h72, 0, 1);
        chk("post_rst_head", data_out, 32'h3000_0071);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("post_rst_empty", {31'b0, empty}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
